// File: rtl/al_phy_clkdiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : al_phy_clkdiv_seq_pkg
// Brief  : State encodings, default cycle constants and output decode for the
//          IO clock / divider realignment sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package al_phy_clkdiv_seq_pkg;

  localparam logic [2:0] SEQ_IDLE = 3'd0;
  localparam logic [2:0] SEQ_STOP = 3'd1;
  localparam logic [2:0] SEQ_RST  = 3'd2;
  localparam logic [2:0] SEQ_WAIT = 3'd3;
  localparam logic [2:0] SEQ_RLS  = 3'd4;

  localparam int DEF_STOP_CYC  = 4;
  localparam int DEF_RST_CYC   = 8;
  localparam int DEF_RLS_CYC   = 4;
  localparam int DEF_START_CYC = 4;
  localparam int DEF_CNT_W     = 8;

  typedef struct packed {
    logic stop;
    logic div_rst;
    logic div_rls;
    logic busy;
  } seq_out_t;

  // Output levels held while resident in a given state
  function automatic seq_out_t seq_decode(input logic [2:0] st);
    seq_out_t o;
    o = '{stop: 1'b0, div_rst: 1'b0, div_rls: 1'b1, busy: 1'b0};
    case (st)
      SEQ_STOP: o = '{stop: 1'b1, div_rst: 1'b0, div_rls: 1'b1, busy: 1'b1};
      SEQ_RST:  o = '{stop: 1'b1, div_rst: 1'b1, div_rls: 1'b0, busy: 1'b1};
      SEQ_WAIT: o = '{stop: 1'b1, div_rst: 1'b0, div_rls: 1'b0, busy: 1'b1};
      SEQ_RLS:  o = '{stop: 1'b0, div_rst: 1'b0, div_rls: 1'b1, busy: 1'b1};
      default:  o = '{stop: 1'b0, div_rst: 1'b0, div_rls: 1'b1, busy: 1'b0};
    endcase
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/al_phy_clkdiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module : al_phy_clkdiv_seq_if
// Brief  : Request/status and clock-primitive control bundle of the sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface al_phy_clkdiv_seq_if;

  logic align_req;
  logic stop;
  logic div_rst;
  logic div_rls;
  logic busy;
  logic done;

  modport master (
    output align_req,
    input  stop,
    input  div_rst,
    input  div_rls,
    input  busy,
    input  done
  );

  modport slave (
    input  align_req,
    output stop,
    output div_rst,
    output div_rls,
    output busy,
    output done
  );

endinterface
`default_nettype wire

// File: rtl/al_phy_dly_cnt.sv
`default_nettype none
// ============================================================================
// Module : al_phy_dly_cnt
// Brief  : Loadable down-counter with zero flag; load has priority over dec.
// Rev    : 1.0  initial release
// ============================================================================
module al_phy_dly_cnt #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  wire logic             clki,
  input  wire logic             rstn,
  input  wire logic             load,
  input  wire logic [CNT_W-1:0] load_val,
  input  wire logic             dec,
  output logic      [CNT_W-1:0] count,
  output logic                  zero
);

  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule
`default_nettype wire

// File: rtl/al_phy_clkdiv_seq.sv
`default_nettype none
// ============================================================================
// Module : al_phy_clkdiv_seq
// Brief  : Stop IO clock -> reset divider -> release -> restart IO clock.
//          Optional PLL lock gating via AL_CLKDIV_SEQ_LOCK_EN.
// Rev    : 1.0  initial release
// ============================================================================
module al_phy_clkdiv_seq
  import al_phy_clkdiv_seq_pkg::*;
#(
  parameter int STOP_CYC  = DEF_STOP_CYC,
  parameter int RST_CYC   = DEF_RST_CYC,
  parameter int RLS_CYC   = DEF_RLS_CYC,
  parameter int START_CYC = DEF_START_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  wire logic          clki,
  input  wire logic          rstn,
`ifdef AL_CLKDIV_SEQ_LOCK_EN
  input  wire logic          pll_lock,
`endif
  al_phy_clkdiv_seq_if.slave sif
);

  localparam logic [CNT_W-1:0] C_STOP_LD  = CNT_W'(STOP_CYC - 1);
  localparam logic [CNT_W-1:0] C_RST_LD   = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] C_RLS_LD   = CNT_W'(RLS_CYC - 1);
  localparam logic [CNT_W-1:0] C_START_LD = CNT_W'(START_CYC - 1);

  logic [2:0]       r_state;
  logic             r_pend;
  seq_out_t         r_out;
  logic             r_done;

  logic [2:0]       w_nxt_state;
  logic             w_pend_nxt;
  logic             w_done_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_dec;
  logic             w_zero;
  logic [CNT_W-1:0] w_count;
  logic             w_lock;

`ifdef AL_CLKDIV_SEQ_LOCK_EN
  logic [1:0] r_lock_sync;

  // Lock is treated as lost until it has crossed both sync stages
  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      r_lock_sync <= 2'b00;
    end else begin
      r_lock_sync <= {r_lock_sync[0], pll_lock};
    end
  end

  assign w_lock = r_lock_sync[1];
`else
  assign w_lock = 1'b1;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_pend_nxt  = r_pend;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    if (!w_lock) begin
      w_nxt_state = SEQ_RST;
      w_load      = 1'b1;
      w_load_val  = C_RST_LD;
      w_pend_nxt  = 1'b0;
    end else begin
      if ((r_state != SEQ_IDLE) && sif.align_req) begin
        w_pend_nxt = 1'b1;
      end
      case (r_state)
        SEQ_IDLE: begin
          if (sif.align_req || r_pend) begin
            w_nxt_state = SEQ_STOP;
            w_load      = 1'b1;
            w_load_val  = C_STOP_LD;
            w_pend_nxt  = 1'b0;
          end
        end
        SEQ_STOP: begin
          if (w_zero) begin
            w_nxt_state = SEQ_RST;
            w_load      = 1'b1;
            w_load_val  = C_RST_LD;
          end
        end
        SEQ_RST: begin
          if (w_zero) begin
            w_nxt_state = SEQ_WAIT;
            w_load      = 1'b1;
            w_load_val  = C_RLS_LD;
          end
        end
        SEQ_WAIT: begin
          if (w_zero) begin
            w_nxt_state = SEQ_RLS;
            w_load      = 1'b1;
            w_load_val  = C_START_LD;
          end
        end
        SEQ_RLS: begin
          if (w_zero) begin
            w_nxt_state = SEQ_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: begin
          w_nxt_state = SEQ_IDLE;
        end
      endcase
    end
  end

  // Counter idles in SEQ_IDLE so it never wraps while waiting for a request
  assign w_dec = (r_state != SEQ_IDLE) && !w_load;

  al_phy_dly_cnt #(
    .CNT_W   (CNT_W),
    .RST_VAL (C_RST_LD)
  ) u_dly_cnt (
    .clki     (clki),
    .rstn     (rstn),
    .load     (w_load),
    .load_val (w_load_val),
    .dec      (w_dec),
    .count    (w_count),
    .zero     (w_zero)
  );

  // Outputs decoded from the next state so they are registered with it
  always_ff @(posedge clki or negedge rstn) begin
    if (!rstn) begin
      r_state <= SEQ_RST;
      r_pend  <= 1'b0;
      r_out   <= seq_decode(SEQ_RST);
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_pend  <= w_pend_nxt;
      r_out   <= seq_decode(w_nxt_state);
      r_done  <= w_done_nxt;
    end
  end

  assign sif.stop    = r_out.stop;
  assign sif.div_rst = r_out.div_rst;
  assign sif.div_rls = r_out.div_rls;
  assign sif.busy    = r_out.busy;
  assign sif.done    = r_done;

endmodule
`default_nettype wire
